// File: rtl/nios_pio_pkg.sv
// Shared register map and edge-select encodings for the Nios input PIO.
package nios_pio_pkg;

  // Avalon register addresses
  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  // Which transition of the debounced level sets edgecapture
  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/nios_debounce_bit.sv
// One input pin: 2-FF synchroniser followed by a stability counter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module nios_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic stable
);

  localparam int unsigned   CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            meta_q;
  logic            sync_q;
  logic            stable_q;
  logic            stable_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Synchroniser and debounce state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= IDLE_LEVEL;
      sync_q   <= IDLE_LEVEL;
      stable_q <= IDLE_LEVEL;
      cnt_q    <= '0;
    end else begin
      meta_q   <= pin;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Count mismatch cycles; any agreement restarts the count, so it never wraps
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/nios_key_pio_in.sv
// Avalon-MM input PIO: debounced pins, edge capture with W1C, irq mask and
// a level interrupt. Reads are combinational from address with no side effects.
module nios_key_pio_in
  import nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 1,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_dq;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] irqmask_d;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic             wr_en;
  logic             unused_wdata;

  // Only the low WIDTH bits of writedata carry meaning
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nios_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (in_port[i]),
      .stable (stable[i])
    );
  end

  assign wr_en = chipselect & ~write_n;

  // Select the transition of interest on the debounced level
  always_comb begin
    edge_det = '0;
    if (EDGE_TYPE == EDGE_RISING) begin
      edge_det = stable & ~stable_dq;
    end else if (EDGE_TYPE == EDGE_FALLING) begin
      edge_det = ~stable & stable_dq;
    end else begin
      edge_det = stable ^ stable_dq;
    end
  end

  // Register writes; a fresh edge overrides a simultaneous W1C on the same bit
  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_en && (address == PIO_ADDR_IRQMASK)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == PIO_ADDR_EDGECAP)) begin
      edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
    end
    edgecap_d = edgecap_d | edge_det;
  end

  // Edge-detect delay line and control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_dq <= {WIDTH{IDLE_LEVEL}};
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      stable_dq <= stable;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA:    readdata[WIDTH-1:0] = stable;
      PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
      PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      default:          readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios_key_pio_in.sv
// Directed bench for nios_key_pio_in with a queue-based scoreboard: stimulus
// tasks push expected values, a negedge monitor pops and compares them.
module tb_nios_key_pio_in;

  localparam int KRd   = 0;
  localparam int KIrq  = 1;
  localparam int KCnt1 = 2;
  localparam int KCnt3 = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] act;
  logic        req = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  nios_key_pio_in #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE      (1),
    .IDLE_LEVEL     (1'b1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  // Monitor: compare the oldest expectation whenever a sample is requested
  always @(negedge clk) begin
    if (req) begin
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_underflow: sample requested with no expectation");
      end else begin
        cur = sb.pop_front();
        case (cur.kind)
          KRd:     act = readdata;
          KIrq:    act = {31'b0, irq};
          KCnt1:   act = 32'(dut.g_bit[1].u_db.cnt_q);
          default: act = 32'(dut.g_bit[3].u_db.cnt_q);
        endcase
        vectors++;
        if (act !== cur.exp) begin
          miscompares++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", cur.name, act, cur.exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Occupies exactly one clock cycle; sample lands on that cycle's negedge
  task automatic expect_v(input string name, input int kind, input logic [1:0] a,
                          input logic [31:0] v);
    exp_t e;
    e.name     = name;
    e.kind     = kind;
    e.exp      = v;
    address    = a;
    chipselect = 1'b1;
    sb.push_back(e);
    req = 1'b1;
    @(negedge clk);
    #1;
    req        = 1'b0;
    chipselect = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // Reset state and register access
    expect_v("rst_data",     KRd,  2'd0, 32'hF);
    expect_v("rst_irqmask",  KRd,  2'd2, 32'h0);
    expect_v("rst_edgecap",  KRd,  2'd3, 32'h0);
    expect_v("rst_irq",      KIrq, 2'd0, 32'h0);
    expect_v("rsvd_read",    KRd,  2'd1, 32'h0);
    wr(2'd0, 32'h0);
    expect_v("data_ro",      KRd,  2'd0, 32'hF);
    wr(2'd1, 32'hFFFF_FFFF);
    expect_v("rsvd_wr_ign",  KRd,  2'd1, 32'h0);
    wr(2'd2, 32'hFFFF_FFFF);
    expect_v("irqmask_rw",   KRd,  2'd2, 32'hF);
    wr(2'd2, 32'h0);
    expect_v("irqmask_clr",  KRd,  2'd2, 32'h0);

    // Press bit0: level accepted at edge 6, edge captured at edge 7
    in_port = 4'hE;
    tick(5);
    expect_v("press_data_e5", KRd,  2'd0, 32'hF);
    expect_v("press_data_e6", KRd,  2'd0, 32'hE);
    expect_v("press_ec_e7",   KRd,  2'd3, 32'h1);
    expect_v("press_irq_m0",  KIrq, 2'd0, 32'h0);

    // Release is a rising edge and must not be captured
    in_port = 4'hF;
    tick(10);
    expect_v("release_ec",    KRd,  2'd3, 32'h1);
    wr(2'd3, 32'hF);
    expect_v("w1c_all",       KRd,  2'd3, 32'h0);

    // IRQ path
    wr(2'd2, 32'h1);
    expect_v("irq_masked_0",  KIrq, 2'd0, 32'h0);
    in_port = 4'hE;
    tick(8);
    expect_v("irq_set",       KIrq, 2'd0, 32'h1);
    expect_v("irq_ec",        KRd,  2'd3, 32'h1);
    wr(2'd3, 32'h1);
    expect_v("irq_after_w1c", KIrq, 2'd0, 32'h0);
    expect_v("ec_after_w1c",  KRd,  2'd3, 32'h0);
    in_port = 4'hF;
    tick(10);
    expect_v("irq_rel_ec",    KRd,  2'd3, 32'h0);
    expect_v("irq_rel_irq",   KIrq, 2'd0, 32'h0);

    // Glitch on bit1 for 3 cycles: counter peaks at 3 and clears
    in_port = 4'hD;
    tick(3);
    in_port = 4'hF;
    tick(2);
    expect_v("glitch_cnt_pk", KCnt1, 2'd0, 32'h3);
    expect_v("glitch_cnt_0",  KCnt1, 2'd0, 32'h0);
    expect_v("glitch_data",   KRd,   2'd0, 32'hF);
    expect_v("glitch_ec",     KRd,   2'd3, 32'h0);

    // W1C on bit2 in the same cycle its falling edge is detected
    wr(2'd2, 32'h4);
    in_port = 4'hB;
    tick(6);
    wr(2'd3, 32'h4);
    expect_v("coll_ec",       KRd,  2'd3, 32'h4);
    expect_v("coll_irq",      KIrq, 2'd0, 32'h1);
    expect_v("coll_data",     KRd,  2'd0, 32'hB);
    wr(2'd3, 32'h4);
    expect_v("coll_w1c_ec",   KRd,  2'd3, 32'h0);
    expect_v("coll_w1c_irq",  KIrq, 2'd0, 32'h0);
    in_port = 4'hF;
    tick(10);
    expect_v("coll_rel_data", KRd,  2'd0, 32'hF);

    // Reset in the middle of a bit3 debounce
    in_port = 4'h7;
    tick(3);
    expect_v("mid_cnt_1",     KCnt3, 2'd0, 32'h1);
    reset_n = 1'b0;
    #1;
    in_port = 4'hF;
    expect_v("mid_cnt_rst",   KCnt3, 2'd0, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    expect_v("mid_data",      KRd,  2'd0, 32'hF);
    tick(10);
    expect_v("mid_ec",        KRd,  2'd3, 32'h0);
    expect_v("mid_irqmask",   KRd,  2'd2, 32'h0);
    expect_v("mid_irq",       KIrq, 2'd0, 32'h0);

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
